// File: rtl/conv_pkg.sv
// Shared definitions for the conv datapath: controller states and default
// operand widths.
package conv_pkg;

    localparam int ACT_W  = 8;
    localparam int PROD_W = 16;
    localparam int BIAS_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_QUANT = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/conv_accum_seq_requant.sv
// Combinational requantizer: logical right shift of the accumulator,
// saturated to an unsigned 8-bit activation with an overflow indication.
module requant_sat8
    import conv_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [3:0]       i_shift,
    output logic [ACT_W-1:0] o_data,
    output logic             o_ovf
);

    logic [ACC_W-1:0] w_q;

    assign w_q    = i_acc >> i_shift;
    assign o_ovf  = |w_q[ACC_W-1:ACT_W];
    assign o_data = o_ovf ? {ACT_W{1'b1}} : w_q[ACT_W-1:0];

endmodule

// File: rtl/conv_accum_seq.sv
// Accumulates TAPS multiplier products onto a bias, requantizes to 8 bits
// and offers the result on a valid/ready handshake.
module conv_accum_seq
    import conv_pkg::*;
#(
    parameter int TAPS  = 9,
    parameter int ACC_W = 24,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BIAS_W-1:0] bias,
    input  logic [3:0]        shift,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              prod_ready,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACT_W-1:0]  out_data,
    output logic [ACC_W-1:0]  out_acc,
    output logic              sat_flag,
    output logic              err_drop
);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_shift;
    logic               r_clamp;
    logic               r_busy;
    logic               r_out_valid;
    logic [ACT_W-1:0]   r_out_data;
    logic [ACC_W-1:0]   r_out_acc;
    logic               r_sat;
    logic               r_err;

    logic [ACC_W:0]     w_sum;
    logic [ACT_W-1:0]   w_q;
    logic               w_ovf;

    // One extra bit so a carry out of the accumulator is visible for clamping.
    assign w_sum = {1'b0, r_acc} + (ACC_W+1)'(prod);

    requant_sat8 #(.ACC_W(ACC_W)) u_requant (
        .i_acc   (r_acc),
        .i_shift (r_shift),
        .o_data  (w_q),
        .o_ovf   (w_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_clamp     <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_acc   <= '0;
            r_sat       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // A start accepted in the same cycle overrides this below.
            if (prod_valid && (r_state != ST_ACCUM))
                r_err <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc   <= ACC_W'(bias);
                        r_shift <= shift;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_clamp <= 1'b0;
                        r_state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (prod_valid) begin
                        if (w_sum[ACC_W]) begin
                            r_acc   <= '1;
                            r_clamp <= 1'b1;
                        end else begin
                            r_acc <= w_sum[ACC_W-1:0];
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(TAPS-1))
                            r_state <= ST_QUANT;
                    end
                end
                ST_QUANT: begin
                    r_out_data  <= w_q;
                    r_sat       <= r_clamp | w_ovf;
                    r_out_acc   <= r_acc;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign prod_ready = (r_state == ST_ACCUM);
    assign busy       = r_busy;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_acc    = r_out_acc;
    assign sat_flag   = r_sat;
    assign err_drop   = r_err;

endmodule

// File: tb/tb_conv_accum_seq.sv
// Directed bench for conv_accum_seq: a 24-bit and a 17-bit accumulator
// instance share one stimulus stream and are checked against a sum model.
module tb_conv_accum_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bias = '0;
    logic [3:0]  shift = '0;
    logic        prod_valid = 1'b0;
    logic [15:0] prod = '0;
    logic        out_ready = 1'b1;

    logic        prod_ready_a, busy_a, out_valid_a, sat_a, err_a;
    logic [7:0]  out_data_a;
    logic [23:0] out_acc_a;
    logic        prod_ready_b, busy_b, out_valid_b, sat_b, err_b;
    logic [7:0]  out_data_b;
    logic [16:0] out_acc_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    conv_accum_seq #(.TAPS(9), .ACC_W(24), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .shift(shift),
        .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready_a),
        .busy(busy_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_acc(out_acc_a), .sat_flag(sat_a),
        .err_drop(err_a)
    );

    conv_accum_seq #(.TAPS(9), .ACC_W(17), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .shift(shift),
        .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready_b),
        .busy(busy_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_acc(out_acc_b), .sat_flag(sat_b),
        .err_drop(err_b)
    );

    typedef struct {
        longint acc;
        int     data;
        bit     sat;
    } res_t;

    res_t exp_a[$];
    res_t exp_b[$];

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Sum of bias and products with clamping at the accumulator ceiling,
    // then shift and clamp to 255.
    function automatic res_t model(input int b, input int sh, input int base,
                                   input int step, input int accw);
        res_t   r;
        longint lim;
        longint q;
        lim   = (64'(1) << accw) - 1;
        r.acc = b;
        r.sat = 1'b0;
        for (int i = 0; i < 9; i++) begin
            r.acc += base + step * i;
            if (r.acc > lim) begin
                r.acc = lim;
                r.sat = 1'b1;
            end
        end
        q = r.acc >> sh;
        if (q > 255) begin
            r.data = 255;
            r.sat  = 1'b1;
        end else begin
            r.data = int'(q);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and hold-stability checks, evaluated every cycle.
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data;
    logic [23:0] prev_acc;
    logic        prev_sat;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                chk("valid_a_vs_b", out_valid_b, out_valid_a);
                if (prev_hold) begin
                    chk("hold_valid", out_valid_a, 1);
                    chk("hold_data", out_data_a, prev_data);
                    chk("hold_acc", out_acc_a, prev_acc);
                    chk("hold_sat", sat_a, prev_sat);
                end
                if (out_valid_a && out_ready) begin
                    if (exp_a.size() == 0 || exp_b.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        res_t ea, eb;
                        ea = exp_a.pop_front();
                        eb = exp_b.pop_front();
                        chk("acc_a", out_acc_a, ea.acc);
                        chk("data_a", out_data_a, ea.data);
                        chk("sat_a", sat_a, ea.sat);
                        chk("acc_b", out_acc_b, eb.acc);
                        chk("data_b", out_data_b, eb.data);
                        chk("sat_b", sat_b, eb.sat);
                        $display("result: acc24=%0d data24=%0d sat24=%0b | acc17=%0d data17=%0d sat17=%0b",
                                 out_acc_a, out_data_a, sat_a, out_acc_b, out_data_b, sat_b);
                    end
                end
                prev_hold = out_valid_a && !out_ready;
                prev_data = out_data_a;
                prev_acc  = out_acc_a;
                prev_sat  = sat_a;
            end
        end
    end

    // One complete output: model pinned by literals, 9 products, then the
    // latency/handshake sequence. hold>0 stalls out_ready and pokes start and
    // prod_valid during the stall.
    task automatic run(input int b, input int sh, input int base, input int step,
                       input int hold, input longint la_acc, input int la_data,
                       input bit la_sat, input longint lb_acc, input int lb_data,
                       input bit lb_sat);
        res_t ma, mb;
        ma = model(b, sh, base, step, 24);
        mb = model(b, sh, base, step, 17);
        chk("model_acc24", ma.acc, la_acc);
        chk("model_data24", ma.data, la_data);
        chk("model_sat24", ma.sat, la_sat);
        chk("model_acc17", mb.acc, lb_acc);
        chk("model_data17", mb.data, lb_data);
        chk("model_sat17", mb.sat, lb_sat);
        exp_a.push_back(ma);
        exp_b.push_back(mb);
        $display("run: bias=%0d shift=%0d base=%0d step=%0d hold=%0d", b, sh, base, step, hold);

        out_ready = (hold == 0);
        bias  = 16'(b);
        shift = 4'(sh);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy_a, 1);
        chk("err_cleared", err_a, 0);
        chk("prod_ready", prod_ready_a, 1);
        for (int i = 0; i < 9; i++) begin
            prod_valid = 1'b1;
            prod       = 16'(base + step * i);
            tick();
        end
        prod_valid = 1'b0;
        chk("lat_quant_valid", out_valid_a, 0);
        chk("lat_quant_ready", prod_ready_a, 0);
        tick();
        chk("lat_valid_up", out_valid_a, 1);
        for (int k = 0; k < hold; k++) begin
            if (k == 1) start = 1'b1;
            if (k == 2) begin
                prod_valid = 1'b1;
                prod       = 16'd1000;
            end
            tick();
            start      = 1'b0;
            prod_valid = 1'b0;
            chk("hold_busy", busy_a, 1);
            chk("hold_valid_up", out_valid_a, 1);
        end
        if (hold > 0) begin
            chk("err_in_out", err_a, 1);
            out_ready = 1'b1;
        end
        tick();
        chk("valid_dropped", out_valid_a, 0);
        chk("busy_dropped", busy_a, 0);
        tick();
        chk("idle_busy", busy_a, 0);
        chk("idle_prod_ready", prod_ready_a, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", out_valid_a, 0);
        chk("rst_data", out_data_a, 0);
        chk("rst_acc", out_acc_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_prod_ready", prod_ready_a, 0);
        rst_n = 1'b1;
        tick();

        run(0, 4, 100, 0, 0, 900, 56, 0, 900, 56, 0);
        run(10, 0, 65025, 0, 0, 585235, 255, 1, 131071, 255, 1);
        run(0, 8, 65025, 0, 0, 585225, 255, 1, 131071, 255, 1);

        prod_valid = 1'b1;
        prod       = 16'd500;
        tick();
        prod_valid = 1'b0;
        chk("err_in_idle", err_a, 1);
        chk("err_in_idle_b", err_b, 1);
        tick();
        run(5, 2, 1, 1, 5, 50, 12, 0, 50, 12, 0);

        // Abort after 4 of 9 products.
        bias  = 16'd0;
        shift = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            prod_valid = 1'b1;
            prod       = 16'd7;
            tick();
        end
        prod_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_a, 0);
        chk("abort_prod_ready", prod_ready_a, 0);
        chk("abort_valid", out_valid_a, 0);
        chk("abort_data", out_data_a, 0);
        chk("abort_acc", out_acc_a, 0);
        chk("abort_sat", sat_a, 0);
        $display("abort: reset asserted after 4 products");
        tick();
        rst_n = 1'b1;
        tick();
        run(0, 0, 1, 0, 0, 9, 9, 0, 9, 9, 0);

        repeat (2) tick();
        chk("queue_drained", exp_a.size() + exp_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
